// File: rtl/layer2_conv_sched.sv
// Layer-2 convolution scheduler: walks every KxK window of the input feature map, streams one
// feature-map/weight tap address per cycle to the conv array, then emits each window's result.
module layer2_conv_sched #(
  parameter int unsigned IN_W  = 12,
  parameter int unsigned K     = 5,
  parameter int unsigned TAPS  = 25,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned AW    = 8
) (
  input  logic          clk_in,
  input  logic          rst_n,
  input  logic          layer_start,
  output logic [AW-1:0] fm_rd_addr,
  output logic [AW-1:0] wt_rd_addr,
  output logic          tap_valid,
  output logic          conv_start,
  input  logic          conv_ready,
  output logic          out_valid,
  output logic [AW-1:0] out_addr,
  output logic          busy,
  output logic          done
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StStart   = 3'd1;
  localparam logic [2:0] StStream  = 3'd2;
  localparam logic [2:0] StWaitRdy = 3'd3;
  localparam logic [2:0] StEmit    = 3'd4;
  localparam logic [2:0] StNext    = 3'd5;
  localparam logic [2:0] StFin     = 3'd6;

  localparam logic [AW-1:0] InW     = AW'(IN_W);
  localparam logic [AW-1:0] KEdge   = AW'(K);
  localparam logic [AW-1:0] OutW    = AW'(OUT_W);
  localparam logic [AW-1:0] LastK   = AW'(K - 1);
  localparam logic [AW-1:0] LastTap = AW'(TAPS - 1);
  localparam logic [AW-1:0] LastOut = AW'(OUT_W - 1);

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] row_q, row_d;
  logic [AW-1:0] col_q, col_d;
  logic [AW-1:0] ky_q, ky_d;
  logic [AW-1:0] kx_q, kx_d;
  logic [AW-1:0] tap_q, tap_d;
  logic [AW-1:0] fm_q, fm_d;
  logic [AW-1:0] wt_q, wt_d;
  logic [AW-1:0] oa_q, oa_d;
  logic          issue;
  logic          tap_valid_q;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    ky_d    = ky_q;
    kx_d    = kx_q;
    tap_d   = tap_q;
    fm_d    = fm_q;
    wt_d    = wt_q;
    oa_d    = oa_q;
    issue   = 1'b0;
    case (state_q)
      StIdle: begin
        if (layer_start) begin
          row_d   = '0;
          col_d   = '0;
          ky_d    = '0;
          kx_d    = '0;
          tap_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        // Preload tap 0 so the address is on the bus in the first STREAM cycle.
        ky_d    = '0;
        kx_d    = '0;
        tap_d   = '0;
        fm_d    = row_q * InW + col_q;
        wt_d    = '0;
        state_d = StStream;
      end
      StStream: begin
        issue = 1'b1;
        if (tap_q == LastTap) begin
          state_d = StWaitRdy;
        end else begin
          tap_d = tap_q + 1'b1;
          if (kx_q == LastK) begin
            kx_d = '0;
            ky_d = ky_q + 1'b1;
          end else begin
            kx_d = kx_q + 1'b1;
          end
          fm_d = (row_q + ky_d) * InW + col_q + kx_d;
          wt_d = ky_d * KEdge + kx_d;
        end
      end
      StWaitRdy: begin
        if (conv_ready) begin
          state_d = StEmit;
        end
      end
      StEmit: begin
        // Conv array output register settles this cycle; result is flagged in NEXT.
        oa_d    = row_q * OutW + col_q;
        state_d = StNext;
      end
      StNext: begin
        state_d = StStart;
        if (col_q == LastOut) begin
          col_d = '0;
          if (row_q == LastOut) begin
            state_d = StFin;
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= StIdle;
      row_q       <= '0;
      col_q       <= '0;
      ky_q        <= '0;
      kx_q        <= '0;
      tap_q       <= '0;
      fm_q        <= '0;
      wt_q        <= '0;
      oa_q        <= '0;
      tap_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      ky_q        <= ky_d;
      kx_q        <= kx_d;
      tap_q       <= tap_d;
      fm_q        <= fm_d;
      wt_q        <= wt_d;
      oa_q        <= oa_d;
      tap_valid_q <= issue;
    end
  end

  assign fm_rd_addr = fm_q;
  assign wt_rd_addr = wt_q;
  assign out_addr   = oa_q;
  assign tap_valid  = tap_valid_q;
  assign conv_start = (state_q == StStart);
  assign out_valid  = (state_q == StNext);
  assign done       = (state_q == StFin);
  assign busy       = (state_q != StIdle) && (state_q != StFin);

endmodule

// File: tb/tb_layer2_conv_sched.sv
// Scoreboard bench for layer2_conv_sched: a window-walk model queues expected tap addresses and
// output positions; monitor and conv-array responder processes check the DUT as it runs.
module tb_layer2_conv_sched;

  localparam int IN_W  = 12;
  localparam int K     = 5;
  localparam int TAPS  = 25;
  localparam int OUT_W = 8;
  localparam int AW    = 8;
  localparam int NWIN  = OUT_W * OUT_W;

  logic          clk_in = 1'b0;
  logic          rst_n;
  logic          layer_start;
  logic [AW-1:0] fm_rd_addr;
  logic [AW-1:0] wt_rd_addr;
  logic          tap_valid;
  logic          conv_start;
  logic          conv_ready;
  logic          out_valid;
  logic [AW-1:0] out_addr;
  logic          busy;
  logic          done;

  layer2_conv_sched #(
    .IN_W (IN_W),
    .K    (K),
    .TAPS (TAPS),
    .OUT_W(OUT_W),
    .AW   (AW)
  ) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .layer_start(layer_start),
    .fm_rd_addr (fm_rd_addr),
    .wt_rd_addr (wt_rd_addr),
    .tap_valid  (tap_valid),
    .conv_start (conv_start),
    .conv_ready (conv_ready),
    .out_valid  (out_valid),
    .out_addr   (out_addr),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int vectors = 0;
  int errors  = 0;

  int out_q[$];
  int fm_q[$];
  int wt_q[$];

  int m_starts = 0, m_taps = 0, m_outs = 0;
  int ready_cyc = -100;
  int rwin = 0;
  int fixed_delay = 3;
  bit spurious_mode = 1'b0;
  bit stall_mode = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_all_zero();
    check("zero_fm_rd_addr", int'(fm_rd_addr), 0);
    check("zero_wt_rd_addr", int'(wt_rd_addr), 0);
    check("zero_out_addr", int'(out_addr), 0);
    check("zero_tap_valid", int'(tap_valid), 0);
    check("zero_conv_start", int'(conv_start), 0);
    check("zero_out_valid", int'(out_valid), 0);
    check("zero_busy", int'(busy), 0);
    check("zero_done", int'(done), 0);
  endtask

  // Reference: every window in raster order, every tap row-major within the window.
  task automatic push_layer();
    for (int r = 0; r < OUT_W; r++) begin
      for (int c = 0; c < OUT_W; c++) begin
        out_q.push_back(r * OUT_W + c);
        for (int ky = 0; ky < K; ky++) begin
          for (int kx = 0; kx < K; kx++) begin
            fm_q.push_back((r + ky) * IN_W + (c + kx));
            wt_q.push_back(ky * K + kx);
          end
        end
      end
    end
  endtask

  function automatic int last_tap_fm(input int w);
    return (w / OUT_W + K - 1) * IN_W + (w % OUT_W) + K - 1;
  endfunction

  // Monitor: tap data is flagged one cycle after its address, so compare the previous cycle's bus.
  initial begin
    int prev_fm = 0, prev_wt = 0, e = 0;
    forever begin
      @(negedge clk_in);
      if (!rst_n) begin
        if (tap_valid) begin
          m_taps++;
          check("tap_expected", int'(fm_q.size() > 0), 1);
          if (fm_q.size() > 0) begin
            check("tap_fm_addr", prev_fm, fm_q.pop_front());
            check("tap_wt_addr", prev_wt, wt_q.pop_front());
          end
        end
        if (conv_start) begin
          m_starts++;
          check("busy_during_start", int'(busy), 1);
        end
        if (out_valid) begin
          m_outs++;
          check("out_expected", int'(out_q.size() > 0), 1);
          if (out_q.size() > 0) begin
            e = out_q.pop_front();
            check("out_addr", int'(out_addr), e);
            check("out_latency", cyc, ready_cyc + 2);
            check("fm_hold_at_out", int'(fm_rd_addr), last_tap_fm(e));
          end
        end
        if (done) begin
          check("done_starts", m_starts, NWIN);
          check("done_taps", m_taps, NWIN * TAPS);
          check("done_outs", m_outs, NWIN);
          check("done_queue_empty", out_q.size(), 0);
          check("done_busy_low", int'(busy), 0);
          m_starts = 0;
          m_taps   = 0;
          m_outs   = 0;
        end
      end
      prev_fm = int'(fm_rd_addr);
      prev_wt = int'(wt_rd_addr);
    end
  end

  // Conv array model: answers conv_ready some cycles after the last tap of each window.
  initial begin
    int rtaps = 0, d = 0, w = 0;
    bit aborted;
    conv_ready = 1'b0;
    forever begin
      @(negedge clk_in);
      conv_ready = 1'b0;
      if (rst_n) begin
        rtaps = 0;
        continue;
      end
      if (tap_valid) begin
        rtaps++;
        if (spurious_mode && rtaps < 20 && $urandom_range(0, 2) == 0) conv_ready = 1'b1;
        if (rtaps == TAPS) begin
          rtaps = 0;
          w = rwin;
          if (stall_mode && w == 7) d = 100;
          else if (fixed_delay >= 0) d = fixed_delay;
          else d = int'($urandom_range(0, 4));
          aborted = 1'b0;
          for (int i = 0; i < d; i++) begin
            check("wait_no_out_valid", int'(out_valid), 0);
            check("wait_fm_frozen", int'(fm_rd_addr), last_tap_fm(w));
            check("wait_wt_frozen", int'(wt_rd_addr), TAPS - 1);
            @(negedge clk_in);
            if (rst_n) begin
              aborted = 1'b1;
              break;
            end
          end
          if (!aborted) begin
            conv_ready = 1'b1;
            ready_cyc  = cyc;
          end
          rwin++;
        end
      end
    end
  end

  task automatic run_layer(input bit spur_start);
    bit seen = 1'b0;
    @(negedge clk_in);
    push_layer();
    rwin = 0;
    layer_start = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk_in);
      layer_start = 1'b0;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (spur_start && $urandom_range(0, 40) == 0) layer_start = 1'b1;
    end
    layer_start = 1'b0;
    check("layer_done_seen", int'(seen), 1);
  endtask

  initial begin
    int n = 0;
    rst_n = 1'b1;
    layer_start = 1'b0;
    repeat (3) @(negedge clk_in);
    check_all_zero();
    #2 rst_n = 1'b0;
    @(negedge clk_in);
    check_all_zero();

    fixed_delay = 3;
    run_layer(1'b0);

    spurious_mode = 1'b1;
    run_layer(1'b1);
    spurious_mode = 1'b0;

    fixed_delay = -1;
    stall_mode = 1'b1;
    run_layer(1'b0);
    stall_mode = 1'b0;

    // Reset during tap 10 of window 20.
    @(negedge clk_in);
    push_layer();
    rwin = 0;
    layer_start = 1'b1;
    for (int i = 0; i < 5000 && n < 21; i++) begin
      @(negedge clk_in);
      layer_start = 1'b0;
      if (conv_start) n++;
    end
    check("reach_window_20", n, 21);
    repeat (11) @(negedge clk_in);
    check("fm_before_reset", int'(fm_rd_addr), (2 + 2) * IN_W + 4 + 0);
    #2 rst_n = 1'b1;
    #1 check_all_zero();
    out_q.delete();
    fm_q.delete();
    wt_q.delete();
    m_starts = 0;
    m_taps   = 0;
    m_outs   = 0;
    @(negedge clk_in);
    check_all_zero();
    #2 rst_n = 1'b0;
    run_layer(1'b0);

    // Back-to-back layers: second layer_start lands in the cycle after done.
    run_layer(1'b0);
    run_layer(1'b0);

    repeat (3) @(negedge clk_in);
    check("final_busy", int'(busy), 0);
    check("final_done", int'(done), 0);
    check("final_taps_pending", fm_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
